// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, FSM states and
// the ALU-op / mux-select codes (ALU-op values must match the ALU-control decoder).
package multicycle_control_pkg;

    localparam int CTRL_STATE_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [CTRL_STATE_W-1:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_ADDIEX = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_JUMP   = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
    } ctrl_word_t;

    function automatic logic opcode_is_legal(input logic [5:0] opcode);
        logic legal;
        case (opcode)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/multicycle_control_ctrl_out_decode.sv
// Combinational control-word decode from the current FSM state; only the fetch
// strobes and the DECODE illegal flag look at live inputs.
module multicycle_control_ctrl_out_decode
    import multicycle_control_pkg::*;
(
    input  logic [CTRL_STATE_W-1:0]       state,
    input  logic                          mem_ready,
    input  logic [5:0]                    opcode,
    output logic [$bits(ctrl_word_t)-1:0] ctrl
);

    ctrl_word_t cw;

    // Per-state datapath strobes; unused encodings decode to an all-zero word
    always_comb begin
        cw = '0;
        case (state)
            ST_FETCH: begin
                cw.mem_read  = 1'b1;
                cw.alu_src_b = SRCB_FOUR;
                cw.alu_op    = ALUOP_ADD;
                cw.ir_write  = mem_ready;
                cw.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                cw.alu_src_b = SRCB_IMM_SH2;
                cw.alu_op    = ALUOP_ADD;
                cw.illegal   = ~opcode_is_legal(opcode);
            end
            ST_MEMADR, ST_ADDIEX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                cw.mem_read = 1'b1;
                cw.iord     = 1'b1;
            end
            ST_MEMWB: begin
                cw.mem_to_reg = 1'b1;
                cw.reg_write  = 1'b1;
            end
            ST_MEMWR: begin
                cw.mem_write = 1'b1;
                cw.iord      = 1'b1;
            end
            ST_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_B;
                cw.alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                cw.reg_dst   = 1'b1;
                cw.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                cw.alu_src_a     = 1'b1;
                cw.alu_op        = ALUOP_SUB;
                cw.pc_write_cond = 1'b1;
                cw.pc_src        = PCSRC_ALUOUT;
            end
            ST_ADDIWB: begin
                cw.reg_write = 1'b1;
            end
            ST_JUMP: begin
                cw.pc_write = 1'b1;
                cw.pc_src   = PCSRC_JUMP;
            end
            default: cw = '0;
        endcase
    end

    assign ctrl = cw;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core: holds the state register and
// next-state logic; the control word comes from the decode sub-module.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [5:0]         i_opcode,
    input  logic               i_memReady,
    output logic               o_pcWrite,
    output logic               o_pcWriteCond,
    output logic               o_iorD,
    output logic               o_memRead,
    output logic               o_memWrite,
    output logic               o_irWrite,
    output logic               o_memToReg,
    output logic               o_regDst,
    output logic               o_regWrite,
    output logic               o_aluSrcA,
    output logic [1:0]         o_aluSrcB,
    output logic [1:0]         o_aluOp,
    output logic [1:0]         o_pcSrc,
    output logic               o_illegal,
    output logic [STATE_W-1:0] o_state
);

    state_e     state_q;
    state_e     state_d;
    ctrl_word_t cw_s;
    ctrl_word_t out_cw;

    // Next-state sequencing; memory waits hold in FETCH/MEMRD/MEMWR
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = i_memReady ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR: state_d = (i_opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  state_d = i_memReady ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  state_d = ST_FETCH;
            ST_MEMWR:  state_d = i_memReady ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   state_d = ST_ALUWB;
            ST_ALUWB:  state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_ADDIWB: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    multicycle_control_ctrl_out_decode u_ctrl_out_decode (
        .state     (state_q),
        .mem_ready (i_memReady),
        .opcode    (i_opcode),
        .ctrl      (cw_s)
    );

    // Reset forces every output low, including the fetch strobes that would follow i_memReady
    always_comb begin
        out_cw = '0;
        if (i_rst_n) begin
            out_cw = cw_s;
        end else begin
            out_cw = '0;
        end
    end

    assign o_pcWrite     = out_cw.pc_write;
    assign o_pcWriteCond = out_cw.pc_write_cond;
    assign o_iorD        = out_cw.iord;
    assign o_memRead     = out_cw.mem_read;
    assign o_memWrite    = out_cw.mem_write;
    assign o_irWrite     = out_cw.ir_write;
    assign o_memToReg    = out_cw.mem_to_reg;
    assign o_regDst      = out_cw.reg_dst;
    assign o_regWrite    = out_cw.reg_write;
    assign o_aluSrcA     = out_cw.alu_src_a;
    assign o_aluSrcB     = out_cw.alu_src_b;
    assign o_aluOp       = out_cw.alu_op;
    assign o_pcSrc       = out_cw.pc_src;
    assign o_illegal     = out_cw.illegal;
    assign o_state       = i_rst_n ? STATE_W'(state_q) : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level sequencer
// predicts every cycle's control word, plus literal spot checks.
module tb_multicycle_control;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ready  = 1'b1;
    logic [5:0] opcode = 6'h00;

    logic       o_pcWrite, o_pcWriteCond, o_iorD, o_memRead, o_memWrite, o_irWrite;
    logic       o_memToReg, o_regDst, o_regWrite, o_aluSrcA, o_illegal;
    logic [1:0] o_aluSrcB, o_aluOp, o_pcSrc;
    logic [3:0] o_state;

    multicycle_control dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_memReady(ready),
        .o_pcWrite(o_pcWrite), .o_pcWriteCond(o_pcWriteCond), .o_iorD(o_iorD),
        .o_memRead(o_memRead), .o_memWrite(o_memWrite), .o_irWrite(o_irWrite),
        .o_memToReg(o_memToReg), .o_regDst(o_regDst), .o_regWrite(o_regWrite),
        .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB), .o_aluOp(o_aluOp),
        .o_pcSrc(o_pcSrc), .o_illegal(o_illegal), .o_state(o_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       illegal;
    } ctl_t;

    typedef struct {
        ctl_t c;
        logic rst;
    } exp_t;

    localparam int P_FETCH  = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD  = 3;
    localparam int P_MEMWB  = 4, P_MEMWR  = 5, P_EXEC   = 6, P_ALUWB  = 7;
    localparam int P_BRANCH = 8, P_ADDIEX = 9, P_ADDIWB = 10, P_JUMP  = 11;

    exp_t exp_q[$];
    ctl_t act;
    int   n_checks = 0;
    int   n_pass   = 0;

    assign act = {o_pcWrite, o_pcWriteCond, o_iorD, o_memRead, o_memWrite, o_irWrite,
                  o_memToReg, o_regDst, o_regWrite, o_aluSrcA, o_aluSrcB, o_aluOp,
                  o_pcSrc, o_illegal};

    function automatic logic legal_op(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h02) || (op == 6'h04) ||
               (op == 6'h08) || (op == 6'h23) || (op == 6'h2B);
    endfunction

    // Output table of each instruction phase, straight from the behavioural description
    function automatic ctl_t expect_out(input int ph, input logic rdy, input logic [5:0] op);
        ctl_t e;
        e = '0;
        case (ph)
            P_FETCH:  begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
            P_DECODE: begin e.alu_src_b = 2'b11; e.illegal = ~legal_op(op); end
            P_MEMADR: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            P_MEMRD:  begin e.mem_read = 1'b1; e.iord = 1'b1; end
            P_MEMWB:  begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
            P_MEMWR:  begin e.mem_write = 1'b1; e.iord = 1'b1; end
            P_EXEC:   begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
            P_ALUWB:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
            P_BRANCH: begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_write_cond = 1'b1; e.pc_src = 2'b01; end
            P_ADDIEX: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            P_ADDIWB: begin e.reg_write = 1'b1; end
            P_JUMP:   begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    // Drive one cycle just after the rising edge and queue what that cycle must show
    task automatic step(input int ph, input logic rdy, input logic [5:0] op, input logic rstn);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n  = rstn;
        ready  = rdy;
        opcode = op;
        e.c    = rstn ? expect_out(ph, rdy, op) : ctl_t'(0);
        e.rst  = ~rstn;
        exp_q.push_back(e);
    endtask

    task automatic lit(input string name, input logic [3:0] a, input logic [3:0] e);
        n_checks++;
        if (a !== e) $display("FAIL %s actual=%0h required=%0h", name, a, e);
        else         n_pass++;
    endtask

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    // Whole instruction with wf fetch waits and wm memory waits; ready is random where ignored
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        for (int i = 0; i < wf; i++) step(P_FETCH, 1'b0, op, 1'b1);
        step(P_FETCH, 1'b1, op, 1'b1);
        step(P_DECODE, rnd(), op, 1'b1);
        case (op)
            6'h23: begin
                step(P_MEMADR, rnd(), op, 1'b1);
                for (int i = 0; i < wm; i++) step(P_MEMRD, 1'b0, op, 1'b1);
                step(P_MEMRD, 1'b1, op, 1'b1);
                step(P_MEMWB, rnd(), op, 1'b1);
            end
            6'h2B: begin
                step(P_MEMADR, rnd(), op, 1'b1);
                for (int i = 0; i < wm; i++) step(P_MEMWR, 1'b0, op, 1'b1);
                step(P_MEMWR, 1'b1, op, 1'b1);
            end
            6'h00: begin step(P_EXEC, rnd(), op, 1'b1); step(P_ALUWB, rnd(), op, 1'b1); end
            6'h04: step(P_BRANCH, rnd(), op, 1'b1);
            6'h08: begin step(P_ADDIEX, rnd(), op, 1'b1); step(P_ADDIWB, rnd(), op, 1'b1); end
            6'h02: step(P_JUMP, rnd(), op, 1'b1);
            default: ;
        endcase
    endtask

    // Per-cycle comparison against the model, on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act !== e.c || (e.rst && o_state !== 4'h0))
                $display("FAIL ctl_word t=%0t actual=%05h state=%0h required=%05h rst=%0b",
                         $time, act, o_state, e.c, e.rst);
            else
                n_pass++;
        end
    end

    initial begin
        logic [5:0] ops [8];
        exp_t       ez;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h01};

        for (int i = 0; i < 3; i++) begin
            step(P_FETCH, 1'b1, 6'h00, 1'b0);
            #3;
            lit("rst_memread", {3'b0, o_memRead}, 4'h0);
            lit("rst_pcwrite", {3'b0, o_pcWrite}, 4'h0);
        end
        step(P_FETCH, 1'b1, 6'h23, 1'b1);
        #3;
        lit("rel_memread", {3'b0, o_memRead}, 4'h1);
        lit("rel_pcwrite", {3'b0, o_pcWrite}, 4'h1);

        step(P_DECODE, 1'b1, 6'h23, 1'b1); #3; lit("lw_dec_srcb", {2'b0, o_aluSrcB}, 4'h3);
        step(P_MEMADR, 1'b0, 6'h23, 1'b1); #3; lit("lw_adr_regwrite", {3'b0, o_regWrite}, 4'h0);
        step(P_MEMRD, 1'b1, 6'h23, 1'b1);  #3; lit("lw_rd_iord", {3'b0, o_iorD}, 4'h1);
        step(P_MEMWB, 1'b0, 6'h23, 1'b1);  #3;
        lit("lw_wb_regwrite", {3'b0, o_regWrite}, 4'h1);
        lit("lw_wb_memtoreg", {3'b0, o_memToReg}, 4'h1);

        step(P_FETCH, 1'b1, 6'h2B, 1'b1); #3; lit("sw_fetch_regwrite", {3'b0, o_regWrite}, 4'h0);
        step(P_DECODE, 1'b0, 6'h2B, 1'b1);
        step(P_MEMADR, 1'b1, 6'h2B, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(P_MEMWR, 1'b0, 6'h2B, 1'b1); #3; lit("sw_wait_memwrite", {3'b0, o_memWrite}, 4'h1);
        end
        step(P_MEMWR, 1'b1, 6'h2B, 1'b1); #3; lit("sw_done_memwrite", {3'b0, o_memWrite}, 4'h1);
        step(P_FETCH, 1'b0, 6'h00, 1'b1); #3; lit("sw_after_memwrite", {3'b0, o_memWrite}, 4'h0);

        step(P_FETCH, 1'b1, 6'h00, 1'b1);
        step(P_DECODE, 1'b1, 6'h00, 1'b1);
        step(P_EXEC, 1'b1, 6'h00, 1'b1);   #3; lit("r_exec_aluop", {2'b0, o_aluOp}, 4'h2);
        step(P_ALUWB, 1'b0, 6'h00, 1'b1);  #3; lit("r_wb_regdst", {3'b0, o_regDst}, 4'h1);
        step(P_FETCH, 1'b1, 6'h04, 1'b1);
        step(P_DECODE, 1'b0, 6'h04, 1'b1);
        step(P_BRANCH, 1'b1, 6'h04, 1'b1); #3;
        lit("beq_aluop", {2'b0, o_aluOp}, 4'h1);
        lit("beq_pcwritecond", {3'b0, o_pcWriteCond}, 4'h1);

        step(P_FETCH, 1'b1, 6'h3F, 1'b1);
        step(P_DECODE, 1'b1, 6'h3F, 1'b1); #3; lit("ill_pulse", {3'b0, o_illegal}, 4'h1);
        step(P_FETCH, 1'b0, 6'h3F, 1'b1);  #3;
        lit("ill_cleared", {3'b0, o_illegal}, 4'h0);
        lit("ill_no_write", {2'b0, o_regWrite, o_memWrite}, 4'h0);

        for (int k = 0; k < 24; k++)
            run_instr(ops[k % 8], int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

        step(P_FETCH, 1'b1, 6'h2B, 1'b1);
        step(P_DECODE, 1'b1, 6'h2B, 1'b1);
        step(P_MEMADR, 1'b1, 6'h2B, 1'b1);
        step(P_MEMWR, 1'b0, 6'h2B, 1'b1);
        @(posedge clk);
        #1;
        ready = 1'b0;
        ez.c  = '0;
        ez.rst = 1'b1;
        exp_q.push_back(ez);
        #2;
        lit("mid_wait_memwrite", {3'b0, o_memWrite}, 4'h1);
        rst_n = 1'b0;
        #1;
        lit("mid_rst_drop", {3'b0, o_memWrite}, 4'h0);
        step(P_FETCH, 1'b1, 6'h2B, 1'b0);
        step(P_FETCH, 1'b1, 6'h2B, 1'b0);
        step(P_FETCH, 1'b1, 6'h08, 1'b1); #3;
        lit("restart_memread", {3'b0, o_memRead}, 4'h1);
        lit("restart_memwrite", {3'b0, o_memWrite}, 4'h0);
        step(P_DECODE, 1'b0, 6'h08, 1'b1);
        step(P_ADDIEX, 1'b1, 6'h08, 1'b1);
        step(P_ADDIWB, 1'b0, 6'h08, 1'b1);
        run_instr(6'h02, 0, 0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
